// File: rtl/cacheflushctrl_pkg.sv
// Shared cache package.
// - flushstate_t: flush sequencer states.
// - lognumways(): way-index width. The replacement-policy block calls the
//   same function, so both blocks always agree on the way-counter width.
package cacheflushctrl_pkg;

  typedef enum logic [2:0] {IDLE, READ, CHECK, WB, CLEAR, DONE} flushstate_t;

  // A 1-way cache still needs a 1-bit index to keep vector widths legal.
  function automatic int lognumways(input int numways);
    return (numways > 1) ? $clog2(numways) : 1;
  endfunction

endpackage

// File: rtl/decoder.sv
// Binary to one-hot decoder.
// Ports: bin (binary index), decoded (one-hot, bit bin set).
module decoder #(
  parameter int N = 2
) (
  input  logic [N-1:0]      bin,
  output logic [2**N-1:0]   decoded
);

  always_comb begin
    decoded      = '0;
    decoded[bin] = 1'b1;
  end

endmodule

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset.
// Ports: clk, reset, en (load enable), d (next value), q (registered value).
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk)
    if (reset)   q <= '0;
    else if (en) q <= d;

endmodule

// File: rtl/cacheflushctrl.sv
// Cache flush sequencer. Walks every (set, way), writes back valid+dirty lines
// through a WBReq/WBAck handshake, clears their dirty bits, and optionally
// issues a one-cycle whole-array invalidate at the end.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   FlushReq, InvalidateReq    level requests, sampled only in IDLE
//   LineValid, LineDirty       array read data for FlushAdr/FlushWay, valid in CHECK
//   WBAck                      bus interface accepted the writeback
//   FlushAdr, FlushWay         set index / one-hot way being walked
//   FlushAdrSel, Busy          sequencer owns the array (not IDLE)
//   WBReq, ClearDirty          writeback request / dirty-bit clear
//   InvalidateCache, FlushDone one-cycle end-of-operation pulses
// All outputs decode from registered state and counters only.
module cacheflushctrl
  import cacheflushctrl_pkg::*;
#(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                FlushReq,
  input  logic                InvalidateReq,
  input  logic                LineValid,
  input  logic                LineDirty,
  input  logic                WBAck,
  output logic [SETLEN-1:0]   FlushAdr,
  output logic [NUMWAYS-1:0]  FlushWay,
  output logic                FlushAdrSel,
  output logic                WBReq,
  output logic                ClearDirty,
  output logic                InvalidateCache,
  output logic                Busy,
  output logic                FlushDone
);

  localparam int LOGNUMWAYS = lognumways(NUMWAYS);

  flushstate_t             state;
  logic                    invpend;
  logic [LOGNUMWAYS-1:0]   waycnt, waynext;
  logic [SETLEN-1:0]       setcnt, setnext;
  logic [NUMWAYS-1:0]      waydec;
  logic                    start, advance, lastway, lastline;
  logic                    wayen, seten, walk;

  // Counters are cleared on the start of each flush; they otherwise hold the
  // last line after a walk because they never advance past it.
  assign start    = (state == IDLE) & FlushReq;
  assign lastway  = (waycnt == LOGNUMWAYS'(NUMWAYS - 1));
  assign lastline = lastway & (setcnt == SETLEN'(NUMLINES - 1));
  assign advance  = ((state == CHECK) & ~(LineValid & LineDirty)) | (state == CLEAR);
  assign wayen    = start | (advance & ~lastline);
  assign seten    = start | (advance & ~lastline & lastway);
  assign waynext  = start ? '0 : waycnt + LOGNUMWAYS'(1);
  assign setnext  = start ? '0 : setcnt + SETLEN'(1);

  flopenr #(.WIDTH(LOGNUMWAYS)) waycntreg (
    .clk(clk), .reset(reset), .en(wayen), .d(waynext), .q(waycnt)
  );

  flopenr #(.WIDTH(SETLEN)) setcntreg (
    .clk(clk), .reset(reset), .en(seten), .d(setnext), .q(setcnt)
  );

  decoder #(.N(LOGNUMWAYS)) waydecoder (
    .bin(waycnt), .decoded(waydec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      invpend <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (FlushReq) begin
            state   <= READ;
            invpend <= InvalidateReq;   // invalidate after the walk
          end else if (InvalidateReq) begin
            state   <= DONE;
            invpend <= 1'b1;
          end
        READ:  state <= CHECK;
        CHECK:
          if (LineValid & LineDirty) state <= WB;
          else if (lastline)         state <= DONE;
          else                       state <= READ;
        WB:    if (WBAck) state <= CLEAR;
        CLEAR: state <= lastline ? DONE : READ;
        DONE: begin
          invpend <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Way select is only driven while a line is actually being addressed.
  assign walk            = (state == READ) | (state == CHECK) | (state == WB) | (state == CLEAR);
  assign FlushWay        = waydec[NUMWAYS-1:0] & {NUMWAYS{walk}};
  assign FlushAdr        = setcnt;
  assign Busy            = (state != IDLE);
  assign FlushAdrSel     = Busy;
  assign WBReq           = (state == WB);
  assign ClearDirty      = (state == CLEAR);
  assign FlushDone       = (state == DONE);
  assign InvalidateCache = (state == DONE) & invpend;

endmodule

// File: tb/tb_cacheflushctrl.sv
module tb_cacheflushctrl;
  localparam int NW = 2;
  localparam int SL = 2;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset, FlushReq, InvalidateReq, LineValid, LineDirty, WBAck;
  logic [SL-1:0] FlushAdr;
  logic [NW-1:0] FlushWay;
  logic          FlushAdrSel, WBReq, ClearDirty, InvalidateCache, Busy, FlushDone;

  // Array model: valid/dirty bits, written only by the stimulus block.
  logic vmem [NL][NW];
  logic dmem [NL][NW];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cacheflushctrl #(.NUMWAYS(NW), .SETLEN(SL), .NUMLINES(NL)) dut (
    .clk(clk), .reset(reset), .FlushReq(FlushReq), .InvalidateReq(InvalidateReq),
    .LineValid(LineValid), .LineDirty(LineDirty), .WBAck(WBAck),
    .FlushAdr(FlushAdr), .FlushWay(FlushWay), .FlushAdrSel(FlushAdrSel),
    .WBReq(WBReq), .ClearDirty(ClearDirty), .InvalidateCache(InvalidateCache),
    .Busy(Busy), .FlushDone(FlushDone)
  );

  // 1-cycle read latency array
  always @(posedge clk) begin
    LineValid <= vmem[FlushAdr][FlushWay[1]];
    LineDirty <= dmem[FlushAdr][FlushWay[1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Walking line k (k = set*NW + way).
  task automatic expect_line(input string tag, input int k, input bit wb, input bit clr);
    chk({tag, ".adr"},   32'(FlushAdr),   32'(k / NW));
    chk({tag, ".way"},   32'(FlushWay),   32'(1 << (k % NW)));
    chk({tag, ".busy"},  32'(Busy),       32'd1);
    chk({tag, ".sel"},   32'(FlushAdrSel), 32'd1);
    chk({tag, ".wbreq"}, 32'(WBReq),      32'(wb));
    chk({tag, ".clr"},   32'(ClearDirty), 32'(clr));
    chk({tag, ".done"},  32'(FlushDone),  32'd0);
    chk({tag, ".inv"},   32'(InvalidateCache), 32'd0);
  endtask

  task automatic expect_done(input string tag, input bit inv);
    chk({tag, ".busy"},  32'(Busy),       32'd1);
    chk({tag, ".way"},   32'(FlushWay),   32'd0);
    chk({tag, ".wbreq"}, 32'(WBReq),      32'd0);
    chk({tag, ".clr"},   32'(ClearDirty), 32'd0);
    chk({tag, ".done"},  32'(FlushDone),  32'd1);
    chk({tag, ".inv"},   32'(InvalidateCache), 32'(inv));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".busy"},  32'(Busy),       32'd0);
    chk({tag, ".sel"},   32'(FlushAdrSel), 32'd0);
    chk({tag, ".way"},   32'(FlushWay),   32'd0);
    chk({tag, ".wbreq"}, 32'(WBReq),      32'd0);
    chk({tag, ".clr"},   32'(ClearDirty), 32'd0);
    chk({tag, ".done"},  32'(FlushDone),  32'd0);
    chk({tag, ".inv"},   32'(InvalidateCache), 32'd0);
  endtask

  initial begin
    reset = 1'b1; FlushReq = 1'b0; InvalidateReq = 1'b0; WBAck = 1'b0;
    for (int s = 0; s < NL; s++)
      for (int w = 0; w < NW; w++) begin
        vmem[s][w] = 1'b1;
        dmem[s][w] = 1'b0;
      end
    step; step;
    expect_idle("rst");
    chk("rst.adr", 32'(FlushAdr), 32'd0);
    reset = 1'b0;
    step;
    expect_idle("idle0");

    // T1: all clean; FlushReq toggled mid-walk is ignored; done at cycle 17
    FlushReq = 1'b1; step; FlushReq = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      expect_line("t1", (c - 1) / 2, 1'b0, 1'b0);
      if (c == 5) FlushReq = 1'b1;
      if (c == 7) FlushReq = 1'b0;
      step;
    end
    expect_done("t1.c17", 1'b0);
    step;
    expect_idle("t1.c18");

    // T2: (2,way1) dirty, WBAck in third WB cycle; done at cycle 21
    dmem[2][1] = 1'b1;
    FlushReq = 1'b1; step; FlushReq = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      expect_line("t2", (c - 1) / 2, 1'b0, 1'b0);
      step;
    end
    expect_line("t2.wb13", 5, 1'b1, 1'b0); step;
    expect_line("t2.wb14", 5, 1'b1, 1'b0); step;
    expect_line("t2.wb15", 5, 1'b1, 1'b0);
    WBAck = 1'b1; step; WBAck = 1'b0;
    expect_line("t2.clr16", 5, 1'b0, 1'b1);
    dmem[2][1] = 1'b0;
    step;
    for (int c = 17; c <= 20; c++) begin
      expect_line("t2", 6 + (c - 17) / 2, 1'b0, 1'b0);
      step;
    end
    expect_done("t2.c21", 1'b0);
    step;
    expect_idle("t2.end");

    // T3: dirty but invalid line produces no writeback
    vmem[1][0] = 1'b0; dmem[1][0] = 1'b1;
    FlushReq = 1'b1; step; FlushReq = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      expect_line("t3", (c - 1) / 2, 1'b0, 1'b0);
      step;
    end
    expect_done("t3.c17", 1'b0);
    step;
    vmem[1][0] = 1'b1; dmem[1][0] = 1'b0;

    // T4: flush + invalidate together, then invalidate alone
    FlushReq = 1'b1; InvalidateReq = 1'b1; step;
    FlushReq = 1'b0; InvalidateReq = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      expect_line("t4", (c - 1) / 2, 1'b0, 1'b0);
      step;
    end
    expect_done("t4.c17", 1'b1);
    step;
    expect_idle("t4.c18");
    InvalidateReq = 1'b1; step; InvalidateReq = 1'b0;
    expect_done("t4.inv1", 1'b1);
    step;
    expect_idle("t4.inv2");

    // T5: reset during WB, then restart from (0, way0)
    dmem[0][0] = 1'b1;
    FlushReq = 1'b1; step; FlushReq = 1'b0;
    expect_line("t5.c1", 0, 1'b0, 1'b0); step;
    expect_line("t5.c2", 0, 1'b0, 1'b0); step;
    expect_line("t5.c3", 0, 1'b1, 1'b0);
    reset = 1'b1; step; reset = 1'b0;
    expect_idle("t5.rst");
    chk("t5.rst.adr", 32'(FlushAdr), 32'd0);
    step;
    expect_idle("t5.idle");
    FlushReq = 1'b1; step; FlushReq = 1'b0;
    expect_line("t5.r1", 0, 1'b0, 1'b0); step;
    expect_line("t5.r2", 0, 1'b0, 1'b0); step;
    expect_line("t5.r3", 0, 1'b1, 1'b0);
    WBAck = 1'b1; step; WBAck = 1'b0;
    expect_line("t5.r4", 0, 1'b0, 1'b1);
    dmem[0][0] = 1'b0;
    step;
    for (int c = 5; c <= 18; c++) begin
      expect_line("t5", 1 + (c - 5) / 2, 1'b0, 1'b0);
      step;
    end
    expect_done("t5.c19", 1'b0);
    step;
    expect_idle("t5.end");

    // T6: FlushReq held across DONE restarts two cycles after FlushDone
    FlushReq = 1'b1; step;
    for (int c = 1; c <= 16; c++) begin
      expect_line("t6", (c - 1) / 2, 1'b0, 1'b0);
      step;
    end
    expect_done("t6.c17", 1'b0);
    step;
    expect_idle("t6.c18");
    step;
    expect_line("t6.c19", 0, 1'b0, 1'b0);
    FlushReq = 1'b0;
    step;
    for (int c = 20; c <= 34; c++) begin
      expect_line("t6b", (c - 19) / 2, 1'b0, 1'b0);
      step;
    end
    expect_done("t6.c35", 1'b0);
    step;
    expect_idle("t6.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheflushctrl.md
# cacheflushctrl

Sequencer that walks every set and way of a set-associative cache to write back dirty lines and, on request, invalidate the whole array. It drives the flush address and way into the cache address mux, handshakes each dirty-line writeback with the bus interface, and clears dirty bits. The replacement-policy block (LRU or LFSR) is frozen while it runs.

## Interface
- NUMWAYS, 4, associativity; power of two, ≥2
- SETLEN, 9, set-index width
- NUMLINES, 128, sets walked; ≤ 2**SETLEN
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- FlushReq  in  1  start a flush; level, sampled only in IDLE
- InvalidateReq  in  1  invalidate all lines; level, sampled only in IDLE
- LineValid  in  1  valid bit of (FlushAdr, FlushWay); array read data, valid in CHECK
- LineDirty  in  1  dirty bit of (FlushAdr, FlushWay); valid in CHECK
- WBAck  in  1  bus interface has accepted the current writeback
- FlushAdr  out  SETLEN  set index being flushed
- FlushWay  out  NUMWAYS  one-hot way being flushed; 0 outside READ/CHECK/WB/CLEAR
- FlushAdrSel  out  1  steer cache set mux to FlushAdr (= Busy)
- WBReq  out  1  write back line at FlushAdr/FlushWay
- ClearDirty  out  1  clear dirty bit of FlushAdr/FlushWay
- InvalidateCache  out  1  one-cycle clear of all valid bits
- Busy  out  1  not IDLE; gates LRUWriteEn and CacheEn for CPU traffic
- FlushDone  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, CHECK, WB, CLEAR, DONE.
- IDLE: on FlushReq → READ, set counter = 0, way counter = 0, latch InvPend = InvalidateReq. On InvalidateReq alone → DONE with InvPend = 1. Neither → stay.
- READ: array addressed with FlushAdr/FlushWay; → CHECK.
- CHECK: if LineValid & LineDirty → WB. Otherwise advance; → DONE if last line, else READ.
- WB: WBReq = 1; FlushAdr/FlushWay held stable. WBAck → CLEAR; else stay.
- CLEAR: ClearDirty = 1 for one cycle; advance; → DONE if last line, else READ.
- Advance: way counter increments first (binary, LOGNUMWAYS = $clog2(NUMWAYS) bits). On wrap from NUMWAYS-1 to 0, set counter increments. Last line = set NUMLINES-1, way NUMWAYS-1. The counter never wraps past it.
- DONE: FlushDone = 1; InvalidateCache = InvPend; clear InvPend; → IDLE.
- FlushReq and InvalidateReq asserted together: flush runs first, then the single invalidation happens in DONE.
- A clean or invalid line generates no WBReq and no ClearDirty.
- Requests that arrive while Busy are ignored. They are not queued. A level still high when IDLE is re-entered starts a new operation on the following cycle.
- reset in any state, including WB with WBReq high: next cycle is IDLE, counters = 0, InvPend = 0, every output 0. No ClearDirty is issued for the aborted line. The bus interface shares this reset.

## Timing
- Reset values: FlushAdr = 0, FlushWay = 0, and WBReq, ClearDirty, InvalidateCache, Busy, FlushAdrSel, FlushDone all 0.
- All outputs are Moore (decoded from state and registered counters). There are no combinational paths from inputs to outputs.
- FlushReq sampled high in IDLE at cycle 0 → READ at cycle 1.
- Per line cost:
  - Clean line: 2 cycles.
  - Dirty line: 4 + (ack wait) cycles. WBAck in the first WB cycle gives exactly 4.
- All-clean flush: FlushDone at cycle 2·NUMLINES·NUMWAYS + 1.
- Invalidate-only: InvalidateCache and FlushDone both at cycle 1.
- LineValid/LineDirty are sampled only in CHECK, one cycle after the address is presented. This matches the array's 1-cycle read latency.

## Structure
- Shared package (cache package) holds:
  - typedef enum logic [2:0] flushstate_t {IDLE, READ, CHECK, WB, CLEAR, DONE};
  - the LOGNUMWAYS derivation, so the replacement-policy block uses the same one.
- Counters use existing flopenr. The way index → FlushWay one-hot conversion reuses the existing decoder #(LOGNUMWAYS) sub-module, ANDed with the walk-state qualifier. No other sub-modules.

## Test plan
- Params NUMWAYS=2, NUMLINES=4; all lines clean; FlushReq pulse at cycle 0 → FlushAdr/FlushWay visit (0,01),(0,10),(1,01)…(3,10). No WBReq. FlushDone only at cycle 17. Busy high cycles 1–17.
- Same params; (2,way1) valid+dirty; WBAck delayed 3 cycles → WBReq held 3 cycles with FlushAdr=2, FlushWay=10 stable. ClearDirty for one cycle. FlushDone at cycle 21.
- Line dirty but invalid → no WBReq, no ClearDirty.
- FlushReq and InvalidateReq high together → full walk, then InvalidateCache and FlushDone in the same cycle. InvalidateReq alone → both at cycle 1, Busy only at cycle 1.
- reset asserted while in WB → next cycle all outputs 0. A subsequent FlushReq restarts at (0, way0).
- FlushReq held high across DONE → new walk begins at READ two cycles after the FlushDone cycle. FlushReq toggled mid-walk → no effect.
